store_buffer: RTL and testbench
===============================

# store_buffer

Parametrised in-order store buffer between the MEM stage and data memory. Stores are allocated at MEM with address, data and size. They are marked committed when the ROB retires them, and drained to memory in program order through a valid/ready port. Younger loads get byte-granular forwarding from buffered stores. A flush discards all uncommitted entries. This generalises the fixed 4-entry buffer indexed by `store_buffer_idx_t`: depth is a parameter, and byte/half/word stores, partial-hit detection and flush recovery are new.

## Interface
- DEPTH, 4: entry count; power of two, ≥2.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; fixed at 32 (4 byte lanes).

- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- alloc_valid_i  in  1  MEM requests an entry.
- alloc_ready_o  out  1  not full and no flush this cycle.
- alloc_addr_i  in  ADDR_W  store byte address.
- alloc_data_i  in  32  store data, LSB-aligned.
- alloc_size_i  in  2  mem_size_t: 00 byte, 01 half, 10 word.
- alloc_idx_o  out  $clog2(DEPTH)  index given to this store (tail slot).
- commit_valid_i  in  1  ROB retires the oldest uncommitted store.
- commit_idx_i  in  $clog2(DEPTH)  index being retired.
- flush_i  in  1  discard all uncommitted entries.
- mem_req_valid_o  out  1  oldest committed entry presented.
- mem_req_ready_i  in  1  memory accepts.
- mem_req_addr_o  out  ADDR_W  word-aligned address.
- mem_req_data_o  out  32  lane-aligned data.
- mem_req_be_o  out  4  byte enables.
- ld_valid_i  in  1  load lookup.
- ld_addr_i  in  ADDR_W  load byte address.
- ld_size_i  in  2  mem_size_t.
- fwd_hit_o  out  1  all load bytes supplied by the buffer.
- fwd_partial_o  out  1  some load bytes are covered but not all; the load must stall.
- fwd_data_o  out  32  merged, lane-aligned word; uncovered lanes are 0.
- count_o  out  $clog2(DEPTH)+1  occupied entries.
- empty_o  out  1  count_o == 0.
- err_o  out  1  sticky: commit_idx_i mismatch, or commit with no uncommitted entry.

## Operation
- Three pointers, each $clog2(DEPTH)+1 bits with a wrap bit:
  - head: oldest, next to drain.
  - cmt: next to commit.
  - tail: next to allocate.
- Invariant: head ≤ cmt ≤ tail (modulo); full when tail−head == DEPTH.
- Allocation:
  - Byte enable = size mask shifted by addr[1:0]: byte 0001, half 0011, word 1111.
  - Data is shifted into its lanes at allocation.
  - Misaligned half/word stores are not this block's concern; MEM raises the exception before allocating.
- Commit:
  - Advances cmt by one.
  - commit_idx_i must equal cmt[low bits]; on mismatch cmt still advances and err_o sets.
  - A commit with cmt == tail sets err_o and cmt does not move.
- Drain:
  - mem_req_valid_o = (head != cmt).
  - Outputs come straight from the head entry.
  - head advances on valid && ready.
- Flush:
  - tail ← cmt, applied after any same-cycle commit.
  - Committed entries are kept and keep draining.
- Forwarding, per load lane in the load's byte mask:
  - Candidates: entries in [head, tail) whose addr[ADDR_W-1:2] equals the load's, with that lane enabled.
  - The youngest candidate supplies the lane.
  - hit = all needed lanes covered; partial = some but not all; neither = miss.
  - Outputs are 0 when ld_valid_i is low.
- Simultaneous alloc/commit/drain in one cycle are all legal; count_o = tail−head.

## Timing
- Reset values: all pointers 0; alloc_ready_o=1; mem_req_valid_o=0; fwd_*=0; count_o=0; empty_o=1; err_o=0. Entry payloads are not reset.
- Alloc accepted in cycle N: visible to forwarding and count_o from N+1.
- Commit in cycle N: mem_req_valid_o rises at N+1 at the earliest.
- The drain port holds address, data and byte enables stable while valid && !ready.
- Forwarding is combinational from ld_*, with the same-cycle result.
- Full: alloc_ready_o=0; alloc_valid_i is ignored and no state changes.
- alloc_ready_o is combinational with flush_i: flush and alloc in the same cycle means the alloc is dropped.
- Reset asserted mid-drain empties the buffer immediately; memory must discard any request it has not yet accepted.

## Structure
- Shared package:
  - STORE_BUFFER_SIZE becomes the default for DEPTH.
  - store_buffer_idx_t sized from it.
  - mem_size_t enum (BYTE, HALF, WORD).
  - sb_entry_t struct {addr, data, be}.
  - Functions size_to_be(size, off) and lane_align(data, off).
- One sub-module, sb_fwd_merge: combinational age-ordered per-lane selection over the entry array, given head/tail.

## Test plan
- Reset, then alloc word 0x1000/0xDEADBEEF, commit idx 0, ready=1 → beat addr 0x1000, be 1111, data 0xDEADBEEF; empty_o=1 afterwards.
- Alloc 4 entries with DEPTH=4 → alloc_ready_o=0; a 5th alloc is ignored. Commit and drain one → ready returns; tail wraps and alloc_idx_o=0.
- Store word 0x2000=0x11223344, then byte 0x2001=0xAA; load word 0x2000 → hit, data 0x1122AA44. Load half 0x2002 → hit, data lanes = 0x1122.
- Store byte 0x3000=0x55; load word 0x3000 → partial=1, hit=0. Load byte 0x3004 → miss.
- 3 allocs, commit 1, flush in the same cycle as a commit → 2 committed entries remain, count_o=2, both drain; a same-cycle alloc is dropped.
- Commit with idx 2 while cmt=0 → err_o=1 and stays set until reset. Hold mem_req_ready_i=0 for 5 cycles → drain outputs stable.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the in-order store buffer and its forwarding merge.
package store_buffer_pkg;

    localparam int STORE_BUFFER_SIZE = 4;
    localparam int SB_ADDR_W         = 32;
    localparam int SB_DATA_W         = 32;

    typedef logic [$clog2(STORE_BUFFER_SIZE)-1:0] store_buffer_idx_t;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    // One buffered store: word-aligned address, lane-aligned data, byte enables.
    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [3:0]           be;
    } sb_entry_t;

    // Byte-enable mask of an access of the given size at byte offset off.
    function automatic logic [3:0] size_to_be(mem_size_t size, logic [1:0] off);
        logic [3:0] mask;
        case (size)
            BYTE:    mask = 4'b0001;
            HALF:    mask = 4'b0011;
            WORD:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask << off;
    endfunction

    // Move LSB-aligned store data into the byte lanes it will occupy.
    function automatic logic [SB_DATA_W-1:0] lane_align(logic [SB_DATA_W-1:0] data, logic [1:0] off);
        return data << {off, 3'b000};
    endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Store-to-load forwarding: per-lane youngest-wins selection over live entries [head, tail).
module sb_fwd_merge
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH  = STORE_BUFFER_SIZE,
    parameter  int ADDR_W = SB_ADDR_W,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int PTR_W  = IDX_W + 1
) (
    input  sb_entry_t         entries_i [DEPTH],
    input  logic [PTR_W-1:0]  head_i,
    input  logic [PTR_W-1:0]  tail_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [1:0]        ld_size_i,
    output logic              fwd_hit_o,
    output logic              fwd_partial_o,
    output logic [31:0]       fwd_data_o
);

    logic [PTR_W-1:0]     occ;
    logic [IDX_W-1:0]     slot;
    logic [3:0]           need;
    logic [3:0]           covered;
    logic [31:0]          merged;
    logic [SB_ADDR_W-1:0] ld_word;

    // Walk entries oldest to youngest so a younger store overwrites an older one per lane.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        occ     = tail_i - head_i;
        need    = size_to_be(mem_size_t'(ld_size_i), ld_addr_i[1:0]);
        ld_word = SB_ADDR_W'({ld_addr_i[ADDR_W-1:2], 2'b00});
        covered = '0;
        merged  = '0;
        slot    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = IDX_W'(head_i + PTR_W'(k));
            if (PTR_W'(k) < occ && entries_i[slot].addr == ld_word) begin
                for (int l = 0; l < 4; l++) begin
                    if (need[l] && entries_i[slot].be[l]) begin
                        covered[l]        = 1'b1;
                        merged[8*l +: 8] = entries_i[slot].data[8*l +: 8];
                    end
                end
            end
        end
        fwd_hit_o     = ld_valid_i && (need != 4'b0000) && (covered == need);
        fwd_partial_o = ld_valid_i && (covered != 4'b0000) && (covered != need);
        fwd_data_o    = ld_valid_i ? merged : '0;
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: allocate at MEM, commit at ROB retire, drain committed stores to memory.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH  = STORE_BUFFER_SIZE,
    parameter  int ADDR_W = SB_ADDR_W,
    parameter  int DATA_W = SB_DATA_W,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int PTR_W  = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid_i,
    output logic              alloc_ready_o,
    input  logic [ADDR_W-1:0] alloc_addr_i,
    input  logic [DATA_W-1:0] alloc_data_i,
    input  logic [1:0]        alloc_size_i,
    output logic [IDX_W-1:0]  alloc_idx_o,
    input  logic              commit_valid_i,
    input  logic [IDX_W-1:0]  commit_idx_i,
    input  logic              flush_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [DATA_W-1:0] mem_req_data_o,
    output logic [3:0]        mem_req_be_o,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [1:0]        ld_size_i,
    output logic              fwd_hit_o,
    output logic              fwd_partial_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic [PTR_W-1:0]  count_o,
    output logic              empty_o,
    output logic              err_o
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] cmt_q,  cmt_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             err_q,  err_d;
    logic [PTR_W-1:0] count;
    logic             alloc_fire, drain_fire, commit_ok;
    logic [IDX_W-1:0] head_slot, tail_slot;
    sb_entry_t        alloc_entry;
    sb_entry_t        entries_q [DEPTH];

    // Pointer, handshake and error next-state logic.
    always_comb begin
        head_slot       = head_q[IDX_W-1:0];
        tail_slot       = tail_q[IDX_W-1:0];
        count           = tail_q - head_q;
        alloc_ready_o   = (count != PTR_W'(DEPTH)) && !flush_i;
        alloc_fire      = alloc_valid_i && alloc_ready_o;
        mem_req_valid_o = (head_q != cmt_q);
        drain_fire      = mem_req_valid_o && mem_req_ready_i;
        commit_ok       = commit_valid_i && (cmt_q != tail_q);

        head_d = head_q + PTR_W'(drain_fire);
        cmt_d  = cmt_q + PTR_W'(commit_ok);
        // A flush rewinds tail onto the post-commit cmt, dropping only uncommitted stores.
        tail_d = flush_i ? cmt_d : tail_q + PTR_W'(alloc_fire);

        err_d = err_q;
        if (commit_valid_i && !commit_ok) begin
            err_d = 1'b1;
        end
        if (commit_ok && commit_idx_i != cmt_q[IDX_W-1:0]) begin
            err_d = 1'b1;
        end

        alloc_entry.addr = SB_ADDR_W'({alloc_addr_i[ADDR_W-1:2], 2'b00});
        alloc_entry.data = lane_align(alloc_data_i, alloc_addr_i[1:0]);
        alloc_entry.be   = size_to_be(mem_size_t'(alloc_size_i), alloc_addr_i[1:0]);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
            err_q  <= err_d;
        end
    end

    // Entry payload storage, written at the tail slot on an accepted allocation.
    always_ff @(posedge clk) begin
        // NOTE: payloads carry no reset; the pointers alone decide which entries are live.
        if (alloc_fire) begin
            entries_q[tail_slot] <= alloc_entry;
        end
    end

    assign mem_req_addr_o = ADDR_W'(entries_q[head_slot].addr);
    assign mem_req_data_o = entries_q[head_slot].data;
    assign mem_req_be_o   = entries_q[head_slot].be;
    assign alloc_idx_o    = tail_slot;
    assign count_o        = count;
    assign empty_o        = (count == '0);
    assign err_o          = err_q;

    sb_fwd_merge #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fwd (
        .entries_i     (entries_q),
        .head_i        (head_q),
        .tail_i        (tail_q),
        .ld_valid_i    (ld_valid_i),
        .ld_addr_i     (ld_addr_i),
        .ld_size_i     (ld_size_i),
        .fwd_hit_o     (fwd_hit_o),
        .fwd_partial_o (fwd_partial_o),
        .fwd_data_o    (fwd_data_o)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic vs a queue model.
module tb_store_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int IDX_W  = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              alloc_valid_i;
    logic              alloc_ready_o;
    logic [ADDR_W-1:0] alloc_addr_i;
    logic [31:0]       alloc_data_i;
    logic [1:0]        alloc_size_i;
    logic [IDX_W-1:0]  alloc_idx_o;
    logic              commit_valid_i;
    logic [IDX_W-1:0]  commit_idx_i;
    logic              flush_i;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [ADDR_W-1:0] mem_req_addr_o;
    logic [31:0]       mem_req_data_o;
    logic [3:0]        mem_req_be_o;
    logic              ld_valid_i;
    logic [ADDR_W-1:0] ld_addr_i;
    logic [1:0]        ld_size_i;
    logic              fwd_hit_o;
    logic              fwd_partial_o;
    logic [31:0]       fwd_data_o;
    logic [IDX_W:0]    count_o;
    logic              empty_o;
    logic              err_o;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_valid_i   (alloc_valid_i),
        .alloc_ready_o   (alloc_ready_o),
        .alloc_addr_i    (alloc_addr_i),
        .alloc_data_i    (alloc_data_i),
        .alloc_size_i    (alloc_size_i),
        .alloc_idx_o     (alloc_idx_o),
        .commit_valid_i  (commit_valid_i),
        .commit_idx_i    (commit_idx_i),
        .flush_i         (flush_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_data_o  (mem_req_data_o),
        .mem_req_be_o    (mem_req_be_o),
        .ld_valid_i      (ld_valid_i),
        .ld_addr_i       (ld_addr_i),
        .ld_size_i       (ld_size_i),
        .fwd_hit_o       (fwd_hit_o),
        .fwd_partial_o   (fwd_partial_o),
        .fwd_data_o      (fwd_data_o),
        .count_o         (count_o),
        .empty_o         (empty_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: program-ordered queue of buffered stores, oldest first.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ref_t;

    ref_t mq[$];
    int   n_cmt   = 0;
    int   drained = 0;
    bit   err_m   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        int         nb;
        logic [7:0] m;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        m  = 8'((1 << nb) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] be_bits(input logic [3:0] be);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[8*l +: 8] = {8{be[l]}};
        return r;
    endfunction

    task automatic idle();
        alloc_valid_i   = 1'b0;
        alloc_addr_i    = '0;
        alloc_data_i    = '0;
        alloc_size_i    = 2'd0;
        commit_valid_i  = 1'b0;
        commit_idx_i    = '0;
        flush_i         = 1'b0;
        mem_req_ready_i = 1'b0;
        ld_valid_i      = 1'b0;
        ld_addr_i       = '0;
        ld_size_i       = 2'd0;
    endtask

    task automatic set_alloc(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        alloc_valid_i = 1'b1;
        alloc_addr_i  = a;
        alloc_data_i  = d;
        alloc_size_i  = s;
    endtask

    // Compare every combinational output against the model for the current inputs.
    task automatic settle();
        logic [3:0]  need, cov;
        logic [31:0] fd, mask;
        bit          exp_hit, exp_part;
        #1;
        check("alloc_ready", 64'(alloc_ready_o), 64'((mq.size() < DEPTH) && !flush_i));
        check("alloc_idx", 64'(alloc_idx_o), 64'((drained + mq.size()) % DEPTH));
        check("count", 64'(count_o), 64'(mq.size()));
        check("empty", 64'(empty_o), 64'(mq.size() == 0));
        check("err", 64'(err_o), 64'(err_m));
        check("mem_valid", 64'(mem_req_valid_o), 64'(n_cmt > 0));
        if (n_cmt > 0) begin
            mask = be_bits(mq[0].be);
            check("mem_addr", 64'(mem_req_addr_o), 64'({mq[0].addr[31:2], 2'b00}));
            check("mem_be", 64'(mem_req_be_o), 64'(mq[0].be));
            check("mem_data", 64'(mem_req_data_o & mask), 64'(mq[0].data & mask));
        end
        need = lane_mask(ld_size_i, ld_addr_i[1:0]);
        cov  = '0;
        fd   = '0;
        for (int l = 0; l < 4; l++) begin
            if (need[l]) begin
                for (int j = mq.size() - 1; j >= 0; j--) begin
                    if (mq[j].addr[31:2] == ld_addr_i[31:2] && mq[j].be[l]) begin
                        cov[l]       = 1'b1;
                        fd[8*l +: 8] = mq[j].data[8*l +: 8];
                        break;
                    end
                end
            end
        end
        exp_hit  = ld_valid_i && (need != 0) && (cov == need);
        exp_part = ld_valid_i && (cov != 0) && (cov != need);
        check("fwd_hit", 64'(fwd_hit_o), 64'(exp_hit));
        check("fwd_partial", 64'(fwd_partial_o), 64'(exp_part));
        check("fwd_data", 64'(fwd_data_o), 64'(ld_valid_i ? fd : 32'h0));
    endtask

    // Advance one clock and apply the same-cycle alloc/commit/drain/flush rules to the model.
    task automatic tick();
        bit   afire, dfire;
        ref_t e;
        @(posedge clk);
        afire = alloc_valid_i && (mq.size() < DEPTH) && !flush_i;
        dfire = (n_cmt > 0) && mem_req_ready_i;
        if (commit_valid_i) begin
            if (n_cmt == mq.size()) begin
                err_m = 1'b1;
            end else begin
                if (int'(commit_idx_i) != (drained + n_cmt) % DEPTH) err_m = 1'b1;
                n_cmt++;
            end
        end
        if (dfire) begin
            void'(mq.pop_front());
            n_cmt--;
            drained++;
        end
        if (flush_i) begin
            while (mq.size() > n_cmt) void'(mq.pop_back());
        end
        if (afire) begin
            e.addr = alloc_addr_i;
            e.data = alloc_data_i << (8 * int'(alloc_addr_i[1:0]));
            e.be   = lane_mask(alloc_size_i, alloc_addr_i[1:0]);
            mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        mq.delete();
        n_cmt   = 0;
        drained = 0;
        err_m   = 1'b0;
        #2;
        check("rst_async_count", 64'(count_o), 64'(0));
        check("rst_async_valid", 64'(mem_req_valid_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        apply_reset();

        // Reset state, then a single word store committed and drained.
        settle();
        check("rst_ready", 64'(alloc_ready_o), 64'(1));
        check("rst_err", 64'(err_o), 64'(0));
        tick();
        set_alloc(32'h1000, 32'hDEADBEEF, 2'd2);
        settle(); tick(); idle();
        commit_valid_i = 1'b1; commit_idx_i = 2'd0;
        settle(); tick(); idle();
        mem_req_ready_i = 1'b1;
        settle();
        check("t1_valid", 64'(mem_req_valid_o), 64'(1));
        check("t1_addr", 64'(mem_req_addr_o), 64'h1000);
        check("t1_be", 64'(mem_req_be_o), 64'hF);
        check("t1_data", 64'(mem_req_data_o), 64'hDEADBEEF);
        tick(); idle();
        settle();
        check("t1_empty", 64'(empty_o), 64'(1));
        tick();

        // Fill to DEPTH, rejected 5th alloc, then drain one and wrap the tail.
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(32'h100 + 32'(4 * i), 32'(i), 2'd2);
            settle(); tick();
        end
        set_alloc(32'h200, 32'hBAD, 2'd2);
        settle();
        check("t2_full_ready", 64'(alloc_ready_o), 64'(0));
        tick(); idle();
        commit_valid_i = 1'b1; commit_idx_i = 2'd0;
        settle();
        check("t2_count_full", 64'(count_o), 64'(4));
        tick(); idle();
        mem_req_ready_i = 1'b1;
        settle(); tick(); idle();
        set_alloc(32'h300, 32'h77, 2'd2);
        settle();
        check("t2_ready_back", 64'(alloc_ready_o), 64'(1));
        check("t2_wrap_idx", 64'(alloc_idx_o), 64'(0));
        tick(); idle();

        // Byte-merged forwarding hit and half-word hit.
        apply_reset();
        set_alloc(32'h2000, 32'h11223344, 2'd2); settle(); tick();
        set_alloc(32'h2001, 32'h000000AA, 2'd0); settle(); tick(); idle();
        ld_valid_i = 1'b1; ld_addr_i = 32'h2000; ld_size_i = 2'd2;
        settle();
        check("t3_word_hit", 64'(fwd_hit_o), 64'(1));
        check("t3_word_data", 64'(fwd_data_o), 64'h1122AA44);
        ld_addr_i = 32'h2002; ld_size_i = 2'd1;
        settle();
        check("t3_half_hit", 64'(fwd_hit_o), 64'(1));
        check("t3_half_data", 64'(fwd_data_o), 64'h11220000);
        tick(); idle();

        // Partial coverage and a miss.
        set_alloc(32'h3000, 32'h55, 2'd0); settle(); tick(); idle();
        ld_valid_i = 1'b1; ld_addr_i = 32'h3000; ld_size_i = 2'd2;
        settle();
        check("t4_partial", 64'(fwd_partial_o), 64'(1));
        check("t4_not_hit", 64'(fwd_hit_o), 64'(0));
        ld_addr_i = 32'h3004; ld_size_i = 2'd0;
        settle();
        check("t4_miss", 64'({fwd_hit_o, fwd_partial_o}), 64'(0));
        tick(); idle();

        // Flush in the same cycle as a commit; a same-cycle alloc is dropped.
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(32'h400 + 32'(4 * i), 32'hA0 + 32'(i), 2'd2);
            settle(); tick();
        end
        idle();
        commit_valid_i = 1'b1; commit_idx_i = 2'd0;
        settle(); tick(); idle();
        commit_valid_i = 1'b1; commit_idx_i = 2'd1; flush_i = 1'b1;
        set_alloc(32'h500, 32'hEE, 2'd2);
        settle();
        check("t5_flush_ready", 64'(alloc_ready_o), 64'(0));
        tick(); idle();
        settle();
        check("t5_count", 64'(count_o), 64'(2));
        mem_req_ready_i = 1'b1;
        for (int i = 0; i < 8 && !empty_o; i++) begin
            settle(); tick();
        end
        settle();
        check("t5_drained", 64'(empty_o), 64'(1));
        tick(); idle();

        // Commit with the wrong index; then hold the drain port under backpressure.
        apply_reset();
        set_alloc(32'h600, 32'hCAFEF00D, 2'd2); settle(); tick(); idle();
        commit_valid_i = 1'b1; commit_idx_i = 2'd2;
        settle(); tick(); idle();
        for (int i = 0; i < 5; i++) begin
            settle();
            check("t6_err_sticky", 64'(err_o), 64'(1));
            check("t6_hold_addr", 64'(mem_req_addr_o), 64'h600);
            check("t6_hold_data", 64'(mem_req_data_o), 64'hCAFEF00D);
            tick();
        end

        // Randomized traffic over a small address window so forwarding overlaps are frequent.
        for (int c = 0; c < 1500; c++) begin
            int          s, off;
            logic [31:0] a;
            idle();
            s   = int'($urandom_range(0, 2));
            off = (s == 0) ? int'($urandom_range(0, 3)) : (s == 1) ? 2 * int'($urandom_range(0, 1)) : 0;
            a   = 32'h5000 + 32'(4 * $urandom_range(0, 3)) + 32'(off);
            if ($urandom_range(0, 1) == 1) set_alloc(a, $urandom, 2'(s));
            if (n_cmt < mq.size() && $urandom_range(0, 2) == 0) begin
                commit_valid_i = 1'b1;
                commit_idx_i   = IDX_W'((drained + n_cmt) % DEPTH);
            end
            flush_i         = ($urandom_range(0, 19) == 0);
            mem_req_ready_i = ($urandom_range(0, 1) == 1);
            s   = int'($urandom_range(0, 2));
            off = (s == 0) ? int'($urandom_range(0, 3)) : (s == 1) ? 2 * int'($urandom_range(0, 1)) : 0;
            ld_valid_i = ($urandom_range(0, 3) != 0);
            ld_addr_i  = 32'h5000 + 32'(4 * $urandom_range(0, 3)) + 32'(off);
            ld_size_i  = 2'(s);
            settle();
            tick();
        end

        // Reset while committed stores may still be waiting to drain.
        apply_reset();
        settle();
        check("final_err_clear", 64'(err_o), 64'(0));
        check("final_empty", 64'(empty_o), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
